// File: rtl/rtc_bus_arbiter_if.sv
// Requester handshake and RTC pin bundle shared by the field units and the bus arbiter.
// The arbiter connects through the slave modport; the requester/pin side uses master.
interface rtc_bus_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   rw;
  logic [8*N_REQ-1:0] addr;
  logic [8*N_REQ-1:0] wdata;
  logic [N_REQ-1:0]   ack;
  logic [7:0]         rdata;
  logic               busy;
  logic [7:0]         bus_out;
  logic               bus_oe;
  logic [7:0]         bus_in;
  logic               CS;
  logic               RD;
  logic               WR;
  logic               AD;

  modport master (
    output req, rw, addr, wdata, bus_in,
    input  ack, rdata, busy, bus_out, bus_oe, CS, RD, WR, AD
  );

  modport slave (
    input  req, rw, addr, wdata, bus_in,
    output ack, rdata, busy, bus_out, bus_oe, CS, RD, WR, AD
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Round-robin arbiter for the multiplexed RTC address/data bus: one request at a time runs
// six timed phases (address setup/strobe/hold, data setup/strobe/hold) and then an ack cycle.
module rtc_bus_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned PH_CYC = 4
) (
  input logic              clk,
  input logic              reset,
  rtc_bus_arbiter_if.slave rtc
);
  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (PH_CYC > 1) ? $clog2(PH_CYC) : 1;
  localparam logic [CW-1:0] PhLast   = CW'(PH_CYC - 1);
  localparam logic [GW-1:0] GrantRst = GW'(N_REQ - 1);

  // Timed phases are consecutive so the phase timer can simply step to the next state.
  typedef enum logic [2:0] {
    StIdle, StASet, StAStb, StAHld, StDSet, StDStb, StDHld, StAck
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic [7:0]        addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic [GW-1:0]     pick;
  logic              found;
  logic              phase_end;

  logic              cs_q, cs_d, rd_q, rd_d, wr_q, wr_d, ad_q, ad_d;
  logic              oe_q, oe_d, busy_q, busy_d;
  logic [7:0]        out_q, out_d;
  logic [7:0]        rdata_q;
  logic [N_REQ-1:0]  ack_q, ack_d;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int unsigned off);
    int unsigned s;
    s = (32'(base) + off) % N_REQ;
    return GW'(s);
  endfunction

  // First requester at or after last_grant+1, wrapping.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      if (!found && rtc.req[wrap_idx(last_q, i)]) begin
        found = 1'b1;
        pick  = wrap_idx(last_q, i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rw_d      = rw_q;
    phase_end = (cnt_q == PhLast);

    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StASet;
          cnt_d   = '0;
          grant_d = pick;
          last_d  = pick;
          addr_d  = rtc.addr[8*pick +: 8];
          wdata_d = rtc.wdata[8*pick +: 8];
          rw_d    = rtc.rw[pick];
        end
      end
      StAck: state_d = StIdle;
      default: begin
        if (phase_end) begin
          cnt_d   = '0;
          state_d = state_e'(state_q + 3'd1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Outputs are decoded from the next state so every pin comes straight from a flop.
    cs_d   = 1'b1;
    rd_d   = 1'b1;
    wr_d   = 1'b1;
    ad_d   = 1'b1;
    oe_d   = 1'b0;
    out_d  = out_q;
    ack_d  = '0;
    busy_d = (state_d != StIdle);

    unique case (state_d)
      StASet, StAHld: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        oe_d  = 1'b1;
        out_d = addr_d;
      end
      StAStb: begin
        cs_d  = 1'b0;
        ad_d  = 1'b0;
        oe_d  = 1'b1;
        wr_d  = 1'b0;
        out_d = addr_d;
      end
      StDSet, StDHld: begin
        cs_d = 1'b0;
        oe_d = ~rw_d;
        if (!rw_d) out_d = wdata_d;
      end
      StDStb: begin
        cs_d = 1'b0;
        oe_d = ~rw_d;
        if (rw_d) begin
          rd_d = 1'b0;
        end else begin
          wr_d  = 1'b0;
          out_d = wdata_d;
        end
      end
      StAck: ack_d[grant_d] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      grant_q <= '0;
      last_q  <= GrantRst;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      ad_q    <= 1'b1;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= 8'h00;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ad_q    <= ad_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      out_q   <= out_d;
      ack_q   <= ack_d;
    end
  end

  // Read data is taken on the edge that releases RD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_q <= 8'h00;
    end else if (state_q == StDStb && phase_end && rw_q) begin
      rdata_q <= rtc.bus_in;
    end
  end

  assign rtc.CS      = cs_q;
  assign rtc.RD      = rd_q;
  assign rtc.WR      = wr_q;
  assign rtc.AD      = ad_q;
  assign rtc.bus_oe  = oe_q;
  assign rtc.bus_out = out_q;
  assign rtc.busy    = busy_q;
  assign rtc.ack     = ack_q;
  assign rtc.rdata   = rdata_q;
endmodule
